core_datatable_arb: RTL and testbench
=====================================

# core_datatable_arb

Round-robin arbiter and sequencer that shares the single core-side port (port A) of the bridge data table between up to NREQ core requesters. It accepts single-word read and write requests, issues them to the data table port with registered outputs, and returns read data to the requester that issued the read. An optional per-requester lock holds the grant for atomic multi-word sequences. It sits between core logic and the `datatable_addr/wren/data/q` inputs and outputs of the bridge command handler.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 10, data table word address width
- DW, 32, data width
- RD_LAT, 1, cycles from `datatable_addr` driven to `datatable_q` valid
- clk  in  1  single clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester request; held with its fields until acked
- we  in  NREQ  per-requester 1=write, 0=read
- lock  in  NREQ  per-requester: keep the grant after this transfer
- addr  in  NREQ*AW  packed word addresses; requester i at [i*AW +: AW]
- wdata  in  NREQ*DW  packed write data; requester i at [i*DW +: DW]
- ack  out  NREQ  combinational one-hot grant; the request is accepted in the cycle ack[i]=1
- rvalid  out  NREQ  registered one-hot one-cycle pulse; read data ready for requester i
- rdata  out  DW  registered read data, shared; valid only while any rvalid bit is set
- datatable_addr  out  AW  registered port A address
- datatable_wren  out  1  registered port A write enable
- datatable_data  out  DW  registered port A write data
- datatable_q  in  DW  port A read data

## Operation
- At most one ack bit is set per cycle. ack is all zero when req is all zero.
- Arbitration when unlocked: the first requester with req=1, searching from `ptr` upward modulo NREQ. After a grant to requester i, `ptr` becomes (i+1) mod NREQ.
- Locked state: only the owner can be granted, and requests from other requesters wait.
  - The lock is entered when the owner is granted with lock[owner]=1.
  - The lock is released when the owner is granted with lock[owner]=0, or in any cycle where req[owner]=0 and lock[owner]=0.
  - On release, `ptr` becomes (owner+1) mod NREQ.
- On a grant, the next edge registers the following: `datatable_addr` takes the requester's addr, `datatable_wren` takes we, and `datatable_data` takes wdata.
- In any cycle with no grant, `datatable_wren` is 0 on the next edge, and addr and data hold their previous values.
- Read return:
  - A requester id and read flag shift through a pipeline of RD_LAT+1 stages.
  - When the flag reaches the end of the pipeline, rdata takes `datatable_q` and rvalid[id] pulses for one cycle.
  - Reads return in issue order, and the pipeline accepts one read per cycle.
- Writes produce no response. The ack cycle is the only completion.
- A read to the same address issued in the cycle after a write returns the new data, because the write commits before the read samples.
- Reset values:
  - datatable_addr=0, datatable_wren=0, datatable_data=0
  - rvalid=0, rdata=0
  - ptr=0, unlocked, read pipeline empty
- Reset asserted mid-operation discards in-flight reads, so no rvalid is produced for them. A write registered before reset has already been presented to the port.

## Timing
- ack is asserted in the same cycle as req (cycle 0). The requester may present its next request in cycle 1. Throughput is one transfer per cycle.
- The port command is driven in cycle 1. `datatable_q` is valid in cycle 1+RD_LAT.
- rvalid and rdata are asserted in cycle 2+RD_LAT, which is cycle 3 with the default RD_LAT.
- ack depends combinationally on req, lock, ptr and the lock state only. No other input reaches ack combinationally.
- Back-to-back reads from different requesters return in consecutive cycles, each with its own rvalid bit.

## Test plan
- **Single write then read:** reset, then req0 writes addr 0x005 with data 0xDEADBEEF. Next cycle, req0 reads 0x005.
  - Required: ack0 in both request cycles.
  - Required: wren=1 with addr 0x005 for one cycle.
  - Required: rvalid[0]=1 with rdata 0xDEADBEEF exactly 3 cycles after the read ack.
- **Round-robin fairness:** all four req held high continuously with reads.
  - Required: grants follow 0,1,2,3,0,1...
  - Required: rvalid order matches the grant order, with no gaps.
- **Lock:** req1 holds lock=1 for 3 writes (addr 0x10..0x12) while req0 and req2 are also requesting, then drops lock on a 4th write.
  - Required: ack1 on all 4 transfers with no interleaving.
  - Required: the next grant after the 4th write goes to req2.
- **Lock abandon:** req3 is granted with lock=1, then deasserts both req and lock.
  - Required: in the following cycle, the pending req0 is granted.
- **Reset mid-read:** req2 reads, and reset is asserted in the cycle after ack.
  - Required: no rvalid at any point after reset.
  - Required: all outputs return to 0 and ptr returns to 0, so req0 wins the next contended cycle.
- **Idle:** no requests for 10 cycles.
  - Required: wren=0, ack=0 and rvalid=0 throughout.
  - Required: datatable_addr holds its last value.

Source files
------------

// File: rtl/core_datatable_arb.sv
// Round-robin arbiter/sequencer sharing data table port A between NREQ core requesters.
// Single-word reads and writes, optional grant lock, in-order read return after RD_LAT.

module core_datatable_arb_lane #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          gnt,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          sel_we,
  output logic [AW-1:0] sel_addr,
  output logic [DW-1:0] sel_data
);
  // Gated by the grant so the top can OR-reduce across lanes (grant is one-hot).
  assign sel_we   = gnt & we;
  assign sel_addr = gnt ? addr  : '0;
  assign sel_data = gnt ? wdata : '0;
endmodule

module core_datatable_arb #(
  parameter int NREQ   = 4,
  parameter int AW     = 10,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ-1:0]      lock,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic [AW-1:0]        datatable_addr,
  output logic                 datatable_wren,
  output logic [DW-1:0]        datatable_data,
  input  logic [DW-1:0]        datatable_q
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0] ptr, owner, gnt_id, idx;
  logic           locked, found, release_own;
  logic [NREQ-1:0] cand;
  int             base, scan;

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + IDW'(1);
  endfunction

  // A locked owner that drops both req and lock frees the port in the same
  // cycle, so a waiting requester can be granted without a dead cycle.
  always_comb begin
    cand        = req;
    base        = int'(ptr);
    release_own = 1'b0;
    if (locked) begin
      if (req[owner]) begin
        cand        = '0;
        cand[owner] = 1'b1;
      end else if (!lock[owner]) begin
        release_own = 1'b1;
        base        = int'(next_id(owner));
      end else begin
        cand = '0;
      end
    end
    ack    = '0;
    found  = 1'b0;
    gnt_id = '0;
    scan   = 0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = base + k;
      if (scan >= NREQ) scan = scan - NREQ;
      idx = IDW'(scan);
      if (!found && cand[idx]) begin
        ack[idx] = 1'b1;
        found    = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr    <= '0;
      owner  <= '0;
      locked <= 1'b0;
    end else if (found) begin
      ptr    <= next_id(gnt_id);
      owner  <= gnt_id;
      locked <= lock[gnt_id];
    end else if (release_own) begin
      ptr    <= next_id(owner);
      locked <= 1'b0;
    end
  end

  logic [NREQ-1:0]         lane_we;
  logic [NREQ-1:0][AW-1:0] lane_addr;
  logic [NREQ-1:0][DW-1:0] lane_data;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      core_datatable_arb_lane #(.AW(AW), .DW(DW)) u_lane (
        .gnt      (ack[gi]),
        .we       (we[gi]),
        .addr     (addr[gi*AW +: AW]),
        .wdata    (wdata[gi*DW +: DW]),
        .sel_we   (lane_we[gi]),
        .sel_addr (lane_addr[gi]),
        .sel_data (lane_data[gi])
      );
    end
  endgenerate

  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_data;
  logic          gnt_we;

  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_addr = gnt_addr | lane_addr[i];
      gnt_data = gnt_data | lane_data[i];
    end
  end
  assign gnt_we = |lane_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      datatable_addr <= '0;
      datatable_wren <= 1'b0;
      datatable_data <= '0;
    end else begin
      datatable_wren <= found & gnt_we;
      if (found) begin
        datatable_addr <= gnt_addr;
        datatable_data <= gnt_data;
      end
    end
  end

  // Read tag pipeline: stage 0 aligns with the port command, stage RD_LAT with q.
  logic [RD_LAT:0]          vld_pipe;
  logic [RD_LAT:0][IDW-1:0] id_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= found & ~gnt_we;
      id_pipe[0]  <= gnt_id;
      for (int s = 1; s <= RD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= vld_pipe[RD_LAT] ? (NREQ'(1) << id_pipe[RD_LAT]) : '0;
      if (vld_pipe[RD_LAT]) rdata <= datatable_q;
    end
  end
endmodule

// File: tb/tb_core_datatable_arb.sv
// Bench for core_datatable_arb: directed scenarios plus a randomized run scored
// against a transaction-level model (arbitration rules, expected memory, read queue).

module tb_core_datatable_arb;
  localparam int NREQ = 4, AW = 10, DW = 32, RD_LAT = 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 ram_clr = 1'b1;
  logic [NREQ-1:0]      req = '0, we = '0, lock = '0;
  logic [NREQ*AW-1:0]   addr = '0;
  logic [NREQ*DW-1:0]   wdata = '0;
  logic [NREQ-1:0]      ack, rvalid;
  logic [DW-1:0]        rdata, datatable_data, datatable_q;
  logic [AW-1:0]        datatable_addr;
  logic                 datatable_wren;

  core_datatable_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
    .ack(ack), .rvalid(rvalid), .rdata(rdata), .datatable_addr(datatable_addr),
    .datatable_wren(datatable_wren), .datatable_data(datatable_data), .datatable_q(datatable_q)
  );

  always #5 clk = ~clk;

  // Port A memory with one cycle of read latency; write lands before a later read samples.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= '0;
    end else begin
      if (datatable_wren) ram[datatable_addr] <= datatable_data;
      datatable_q <= ram[datatable_addr];
    end
  end

  typedef struct { int due; int id; logic [DW-1:0] data; } rd_t;
  rd_t           pend[$];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];
  int            m_ptr = 0, m_owner = 0, cyc = 0;
  bit            m_locked = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic          e_wren = 1'b0;
  logic [DW-1:0] e_data = '0, e_rdata = '0;
  logic [NREQ-1:0] c_ack = '0, c_rv = '0;
  logic [AW-1:0] c_addr;
  logic          c_wren;
  logic [DW-1:0] c_data, c_rd;
  int            n_tests = 0, n_fail = 0;

  function automatic bit bitof(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int start);
    for (int k = 0; k < NREQ; k++)
      if (bitof(r, (start + k) % NREQ)) return (start + k) % NREQ;
    return -1;
  endfunction

  task automatic set_req(input int i, input bit r, input bit w, input bit l, input int a,
                         input logic [DW-1:0] d);
    req[i] = r; we[i] = w; lock[i] = l;
    addr[i*AW +: AW] = AW'(a);
    wdata[i*DW +: DW] = d;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_locked = 1'b0;
    pend.delete();
    e_addr = '0; e_wren = 1'b0; e_data = '0; e_rdata = '0;
  endtask

  // Advance the model one cycle; c_* hold what the DUT must show in this cycle.
  task automatic tick();
    int g;
    bit rel;
    @(negedge clk);
    c_addr = e_addr; c_wren = e_wren; c_data = e_data;
    c_rv = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      c_rv = NREQ'(1) << pend[0].id;
      e_rdata = pend[0].data;
      void'(pend.pop_front());
    end
    c_rd = e_rdata;
    g = -1; rel = 1'b0;
    if (m_locked) begin
      if (bitof(req, m_owner)) g = m_owner;
      else if (!bitof(lock, m_owner)) begin rel = 1'b1; g = pick(req, (m_owner + 1) % NREQ); end
    end else begin
      g = pick(req, m_ptr);
    end
    c_ack = '0; e_wren = 1'b0;
    if (g >= 0) begin
      c_ack = NREQ'(1) << g;
      m_ptr = (g + 1) % NREQ; m_owner = g; m_locked = bitof(lock, g);
      e_addr = addr[g*AW +: AW]; e_data = wdata[g*DW +: DW]; e_wren = bitof(we, g);
      if (e_wren) exp_mem[e_addr] = e_data;
      else pend.push_back('{due: cyc + 2 + RD_LAT, id: g, data: exp_mem[e_addr]});
    end else if (rel) begin
      m_ptr = (m_owner + 1) % NREQ; m_locked = 1'b0;
    end
    cyc++;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    req = '0; we = '0; lock = '0; reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (datatable_addr !== '0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", datatable_addr); end
    n_tests++; if (datatable_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren got=%b exp=0", datatable_wren); end
    n_tests++; if (datatable_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", datatable_data); end
    n_tests++; if (rvalid !== '0) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
    n_tests++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    n_tests++; if (ack !== '0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", ack); end
    @(posedge clk); #1;
    reset = 1'b0; ram_clr = 1'b0;
  endtask

  task automatic test_write_read();
    @(posedge clk); #1; set_req(0, 1, 1, 0, 'h005, 32'hDEADBEEF);
    tick();
    n_tests++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL wr_ack got=%b exp=0001", ack); end
    @(posedge clk); #1; set_req(0, 1, 0, 0, 'h005, '0);
    tick();
    n_tests++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL rd_ack got=%b exp=0001", ack); end
    n_tests++; if (datatable_wren !== 1'b1 || datatable_addr !== 10'h005 || datatable_data !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL wr_port got=%b/%h/%h exp=1/005/deadbeef", datatable_wren, datatable_addr, datatable_data); end
    @(posedge clk); #1; req = '0;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) tick(); else tick();
      if (k == 1) begin
        n_tests++; if (datatable_wren !== 1'b0 || datatable_addr !== 10'h005)
          begin n_fail++; $display("FAIL rd_port got=%b/%h exp=0/005", datatable_wren, datatable_addr); end
      end
      n_tests++; if (rvalid !== (k == 3 ? 4'b0001 : 4'b0000))
        begin n_fail++; $display("FAIL wr_rd_rvalid k=%0d got=%b", k, rvalid); end
    end
    n_tests++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_rdata got=%h exp=deadbeef", rdata); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 305; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (n >= 300) set_req(i, 0, 0, 0, 0, '0);
        else if (bitof(c_ack, i) || !bitof(req, i))
          set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 15)), $urandom);
      end
      tick();
      n_tests++; if (ack !== c_ack) begin n_fail++; $display("FAIL rand_ack cyc=%0d got=%b exp=%b", cyc, ack, c_ack); end
      n_tests++; if (datatable_wren !== c_wren || datatable_addr !== c_addr)
        begin n_fail++; $display("FAIL rand_port cyc=%0d got=%b/%h exp=%b/%h", cyc, datatable_wren, datatable_addr, c_wren, c_addr); end
      if (c_wren) begin
        n_tests++; if (datatable_data !== c_data) begin n_fail++; $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", cyc, datatable_data, c_data); end
      end
      n_tests++; if (rvalid !== c_rv) begin n_fail++; $display("FAIL rand_rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, c_rv); end
      if (c_rv !== '0) begin
        n_tests++; if (rdata !== c_rd) begin n_fail++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", cyc, rdata, c_rd); end
      end
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (k >= 12) set_req(i, 0, 0, 0, 0, '0);
        else if (k == 0 || bitof(c_ack, i)) set_req(i, 1, 0, 0, int'($urandom_range(0, 15)), '0);
      end
      tick();
      n_tests++; if (ack !== (k < 12 ? (4'b0001 << (k % 4)) : 4'b0000))
        begin n_fail++; $display("FAIL rr_ack k=%0d got=%b", k, ack); end
      n_tests++; if (rvalid !== (k >= 3 ? (4'b0001 << ((k - 3) % 4)) : 4'b0000))
        begin n_fail++; $display("FAIL rr_rvalid k=%0d got=%b", k, rvalid); end
      if (k >= 3) begin
        n_tests++; if (rdata !== c_rd) begin n_fail++; $display("FAIL rr_rdata k=%0d got=%h exp=%h", k, rdata, c_rd); end
      end
    end
  endtask

  task automatic test_lock();
    logic [DW-1:0] lw [4];
    logic [NREQ-1:0] exp_ack;
    for (int i = 0; i < 4; i++) lw[i] = $urandom;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (k < 4) set_req(1, 1, 1, k < 3, 'h10 + k, lw[k]); else set_req(1, 0, 0, 0, 0, '0);
      if (k == 1) begin set_req(0, 1, 0, 0, 'h10, '0); set_req(2, 1, 0, 0, 'h11, '0); end
      if (k == 5) set_req(2, 0, 0, 0, 0, '0);
      if (k == 6) set_req(0, 0, 0, 0, 0, '0);
      tick();
      case (k)
        0, 1, 2, 3: exp_ack = 4'b0010;
        4:          exp_ack = 4'b0100;
        5:          exp_ack = 4'b0001;
        default:    exp_ack = 4'b0000;
      endcase
      n_tests++; if (ack !== exp_ack) begin n_fail++; $display("FAIL lock_ack k=%0d got=%b exp=%b", k, ack, exp_ack); end
      if (k >= 1 && k <= 4) begin
        n_tests++; if (datatable_wren !== 1'b1 || datatable_addr !== AW'('h10 + k - 1))
          begin n_fail++; $display("FAIL lock_port k=%0d got=%b/%h", k, datatable_wren, datatable_addr); end
      end
      n_tests++; if (rvalid !== c_rv) begin n_fail++; $display("FAIL lock_rvalid k=%0d got=%b exp=%b", k, rvalid, c_rv); end
      if (k == 7 || k == 8) begin
        n_tests++; if (rdata !== lw[k - 7 + (k == 7 ? 1 : -1)])
          begin n_fail++; $display("FAIL lock_rdata k=%0d got=%h", k, rdata); end
      end
    end
  endtask

  task automatic test_lock_abandon();
    logic [NREQ-1:0] exp_ack;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      case (k)
        0: set_req(2, 1, 0, 0, 1, '0);
        1: begin set_req(2, 0, 0, 0, 0, '0); set_req(3, 1, 0, 1, 2, '0); set_req(0, 1, 0, 0, 3, '0); end
        2: set_req(3, 0, 0, 0, 0, '0);
        3: begin set_req(0, 0, 0, 0, 0, '0); set_req(3, 1, 0, 1, 4, '0); end
        4: begin set_req(3, 0, 0, 1, 0, '0); set_req(1, 1, 0, 0, 5, '0); end
        5: set_req(3, 0, 0, 0, 0, '0);
        6: set_req(1, 0, 0, 0, 0, '0);
        default: ;
      endcase
      tick();
      case (k)
        0: exp_ack = 4'b0100;
        1: exp_ack = 4'b1000;
        2: exp_ack = 4'b0001;
        3: exp_ack = 4'b1000;
        5: exp_ack = 4'b0010;
        default: exp_ack = 4'b0000;
      endcase
      n_tests++; if (ack !== exp_ack) begin n_fail++; $display("FAIL abandon_ack k=%0d got=%b exp=%b", k, ack, exp_ack); end
      n_tests++; if (rvalid !== c_rv) begin n_fail++; $display("FAIL abandon_rvalid k=%0d got=%b exp=%b", k, rvalid, c_rv); end
    end
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1; set_req(2, 1, 0, 0, 7, '0);
    tick();
    n_tests++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL mid_ack got=%b exp=0100", ack); end
    @(posedge clk); #1;
    req = '0; reset = 1'b1;
    model_reset();
    @(negedge clk);
    n_tests++; if (datatable_addr !== '0 || datatable_wren !== 1'b0 || datatable_data !== '0 || rdata !== '0)
      begin n_fail++; $display("FAIL mid_reset_out got=%h/%b/%h/%h exp=0", datatable_addr, datatable_wren, datatable_data, rdata); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      tick();
      n_tests++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL mid_rvalid k=%0d got=%b exp=0000", k, rvalid); end
    end
    @(posedge clk); #1; set_req(0, 1, 0, 0, 3, '0); set_req(2, 1, 0, 0, 4, '0);
    tick();
    n_tests++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr_ack got=%b exp=0001", ack); end
    @(posedge clk); #1; req = '0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      tick();
      n_tests++; if (rvalid !== c_rv) begin n_fail++; $display("FAIL mid_drain k=%0d got=%b exp=%b", k, rvalid, c_rv); end
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      req = '0; lock = '0;
      tick();
      n_tests++; if (datatable_wren !== 1'b0 || ack !== '0 || rvalid !== '0)
        begin n_fail++; $display("FAIL idle k=%0d got wren=%b ack=%b rvalid=%b", k, datatable_wren, ack, rvalid); end
      n_tests++; if (datatable_addr !== c_addr)
        begin n_fail++; $display("FAIL idle_addr k=%0d got=%h exp=%h", k, datatable_addr, c_addr); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) exp_mem[i] = '0;
    test_reset();
    test_write_read();
    test_random();
    test_round_robin();
    test_lock();
    test_lock_abandon();
    test_reset_mid_read();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
